pixl_conv_ctrl: RTL and testbench
=================================

PIXL_CONV_CTRL -- requirements
Module: pixl_conv_ctrl

Interface
REQ-001 The block SHALL have parameter N_TAPS, default 9, meaning the number of kernel coefficients and pixels per frame (3x3 window).
REQ-002 The block SHALL have parameter ACC_W, default 24, meaning the accumulator width; it SHALL be at least 16+ceil(log2(N_TAPS)).
REQ-003 The block SHALL have port clk, input, 1 bit: single clock; all state updates on rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port rx_empty, input, 1 bit: UART receive FIFO empty.
REQ-006 The block SHALL have port r_data, input, 8 bits: UART receive FIFO head byte (show-ahead).
REQ-007 The block SHALL have port rd_uart, output, 1 bit: one-cycle pop of receive FIFO.
REQ-008 The block SHALL have port tx_full, input, 1 bit: UART transmit FIFO full.
REQ-009 The block SHALL have port w_data, output, 8 bits: byte to transmit FIFO.
REQ-010 The block SHALL have port wr_uart, output, 1 bit: one-cycle push to transmit FIFO.
REQ-011 The block SHALL have port kernel_reload, input, 1 bit: request to reload kernel after the current frame.
REQ-012 The block SHALL have port busy, output, 1 bit: high in every state except LOAD_K with zero kernel bytes taken.
REQ-013 The block SHALL have port frame_done, output, 1 bit: one-cycle pulse when the last result byte is pushed.

Function
REQ-014 The FSM SHALL have states LOAD_K, LOAD_P, MAC, SEND; the reset state SHALL be LOAD_K.
REQ-015 In LOAD_K and LOAD_P, rd_uart SHALL be asserted in a cycle only if rx_empty=0, and r_data SHALL be captured in that same cycle into kernel[idx] or pixel[idx].
REQ-016 idx SHALL increment per accepted byte; at idx=N_TAPS-1 the FSM SHALL move to LOAD_P from LOAD_K, or to MAC from LOAD_P, with idx cleared.
REQ-017 While rx_empty=1, the block SHALL hold state and idx with no pop issued; at most one pop SHALL occur per cycle.
REQ-018 MAC SHALL clear the accumulator on entry, add kernel[i]*pixel[i] (unsigned 8x8) for i=0..N_TAPS-1 one per cycle, and last exactly N_TAPS cycles.
REQ-019 The accumulator SHALL never wrap: 9*255*255=585225 fits in 24 bits.
REQ-020 SEND SHALL emit the accumulator as 3 bytes, LSB first, on w_data with wr_uart.
REQ-021 wr_uart SHALL be asserted only in cycles where tx_full=0; while tx_full=1 the pending byte SHALL be held and no push issued.
REQ-022 After the third byte, frame_done SHALL pulse in the same cycle as that wr_uart.
REQ-023 After SEND, the next state SHALL be LOAD_K if a reload is pending, else LOAD_P; the kernel is retained across frames otherwise.
REQ-024 A kernel_reload pulse in any state SHALL set a sticky pending flag, cleared on entry to LOAD_K.
REQ-025 Simultaneous kernel_reload and frame_done SHALL be treated as pending, so the next state is LOAD_K.
REQ-026 rd_uart and wr_uart SHALL never be high in the same cycle.

Reset
REQ-027 On reset=0, immediately and regardless of clk: state=LOAD_K, idx=0, accumulator=0, reload flag=0, rd_uart=0, wr_uart=0, frame_done=0, w_data=0, busy=0.
REQ-028 Reset asserted mid-frame SHALL abandon the frame with no further pops or pushes; kernel and pixel registers need not be cleared.
REQ-029 After reset deassertion, the first pop SHALL occur no earlier than the first rising edge with rx_empty=0.

Structure
REQ-030 A shared package pixl_pkg SHALL hold the state enum, N_TAPS, ACC_W, and the result byte count (3).
REQ-031 The multiply-accumulate SHALL be a sub-module pixl_mac (clear, en, a[7:0], b[7:0], acc[ACC_W-1:0]); FSM and register files SHALL live in pixl_conv_ctrl.

Verification
REQ-032 Kernel bytes 0..8, then pixels 1..9, with tx_full=0 -> transmitted bytes F0,00,00 and one frame_done pulse.
REQ-033 All 18 bytes 0xFF -> result 585225 transmitted as 09,EE,08.
REQ-034 rx_empty toggled high for 5 cycles between every byte -> same result as REQ-032, and no rd_uart while rx_empty=1.
REQ-035 tx_full held high 20 cycles during SEND -> no wr_uart while tx_full=1, and byte order/values unchanged.
REQ-036 Second frame pixels 1..9 without reload -> F0,00,00 using the retained kernel; kernel_reload pulsed during MAC -> next 9 bytes load the kernel.
REQ-037 reset=0 asserted after 4 pixel bytes -> outputs at reset values immediately, and a full fresh frame afterwards yields the correct result.

Source files
------------

// File: rtl/pixl_pkg.sv
// Shared types and sizing for the 3x3 pixel convolution controller.
package pixl_pkg;
  localparam int N_TAPS    = 9;
  localparam int ACC_W     = 24;
  localparam int RES_BYTES = 3;

  typedef enum logic [1:0] {LOAD_K, LOAD_P, MAC, SEND} state_e;
endpackage

// File: rtl/pixl_mac.sv
// Unsigned 8x8 multiply-accumulate; clear wins over en.
module pixl_mac #(
  parameter int ACC_W = 24
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             en,
  input  logic [7:0]       a,
  input  logic [7:0]       b,
  output logic [ACC_W-1:0] acc
);
  logic [ACC_W-1:0] acc_q;
  logic [15:0]      prod;

  assign prod = a * b;
  assign acc  = acc_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)     acc_q <= '0;
    else if (clear) acc_q <= '0;
    else if (en)    acc_q <= acc_q + ACC_W'(prod);
  end
endmodule

// File: rtl/pixl_conv_ctrl.sv
// UART-fed 3x3 convolution: load kernel, load pixels, MAC, send 3-byte result.
module pixl_conv_ctrl #(
  parameter int N_TAPS = pixl_pkg::N_TAPS,
  parameter int ACC_W  = pixl_pkg::ACC_W
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_empty,
  input  logic [7:0] r_data,
  output logic       rd_uart,
  input  logic       tx_full,
  output logic [7:0] w_data,
  output logic       wr_uart,
  input  logic       kernel_reload,
  output logic       busy,
  output logic       frame_done
);
  import pixl_pkg::*;

  localparam int IDX_W = (N_TAPS > 1) ? $clog2(N_TAPS) : 1;
  localparam logic [IDX_W-1:0] LAST_TAP  = IDX_W'(N_TAPS - 1);
  localparam logic [1:0]       LAST_BYTE = 2'(RES_BYTES - 1);

  state_e           state_q;
  logic [IDX_W-1:0] idx_q;
  logic [1:0]       byte_q;
  logic             reload_q;
  logic [7:0]       kernel_q [N_TAPS];
  logic [7:0]       pixel_q  [N_TAPS];

  logic                   loading, pop, push, last_tap, mac_clear, mac_en;
  logic [ACC_W-1:0]       acc;
  logic [8*RES_BYTES-1:0] res;

  // Handshakes are combinational against the show-ahead FIFO flags and
  // gated by reset so nothing moves while reset is held.
  assign loading   = (state_q == LOAD_K) || (state_q == LOAD_P);
  assign pop       = reset && !rx_empty && loading;
  assign push      = reset && !tx_full && (state_q == SEND);
  assign last_tap  = (idx_q == LAST_TAP);
  assign mac_clear = pop && (state_q == LOAD_P) && last_tap;
  assign mac_en    = (state_q == MAC);
  assign res       = acc[8*RES_BYTES-1:0];

  assign rd_uart    = pop;
  assign wr_uart    = push;
  assign w_data     = (state_q == SEND) ? res[{byte_q, 3'b000} +: 8] : 8'h00;
  assign frame_done = push && (byte_q == LAST_BYTE);
  assign busy       = !((state_q == LOAD_K) && (idx_q == '0));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= LOAD_K;
      idx_q    <= '0;
      byte_q   <= '0;
      reload_q <= 1'b0;
    end else begin
      if (kernel_reload) reload_q <= 1'b1;
      case (state_q)
        LOAD_K: if (pop) begin
          if (last_tap) begin
            idx_q   <= '0;
            state_q <= LOAD_P;
          end else idx_q <= idx_q + 1'b1;
        end
        LOAD_P: if (pop) begin
          if (last_tap) begin
            idx_q   <= '0;
            state_q <= MAC;
          end else idx_q <= idx_q + 1'b1;
        end
        MAC: begin
          if (last_tap) begin
            idx_q   <= '0;
            state_q <= SEND;
          end else idx_q <= idx_q + 1'b1;
        end
        SEND: if (push) begin
          if (byte_q == LAST_BYTE) begin
            byte_q <= '0;
            // A reload arriving with the final push still counts.
            if (reload_q || kernel_reload) begin
              state_q  <= LOAD_K;
              reload_q <= 1'b0;
            end else state_q <= LOAD_P;
          end else byte_q <= byte_q + 1'b1;
        end
        default: state_q <= LOAD_K;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (pop) begin
      if (state_q == LOAD_K) kernel_q[idx_q] <= r_data;
      else                   pixel_q[idx_q]  <= r_data;
    end
  end

  pixl_mac #(.ACC_W(ACC_W)) u_mac (
    .clk   (clk),
    .reset (reset),
    .clear (mac_clear),
    .en    (mac_en),
    .a     (kernel_q[idx_q]),
    .b     (pixel_q[idx_q]),
    .acc   (acc)
  );
endmodule

// File: tb/tb_pixl_conv_ctrl.sv
// Randomized bench: FIFO-side driver/monitor plus a dot-product reference model.
module tb_pixl_conv_ctrl;
  localparam int N = 9;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       rx_empty = 1'b1;
  logic [7:0] r_data = 8'h00;
  logic       rd_uart;
  logic       tx_full = 1'b0;
  logic [7:0] w_data;
  logic       wr_uart;
  logic       kernel_reload = 1'b0;
  logic       busy;
  logic       frame_done;

  int checks = 0;
  int failures = 0;

  logic [7:0] rx_q[$];
  logic [7:0] tx_got[$];
  bit         fd_got[$];
  int  pop_cnt = 0;
  int  pop_limit = 32'h7fff_ffff;
  int  gap_cnt = 0;
  int  gap_len = 0;
  bit  gap_rand = 0;
  bit  tx_rand = 0;
  bit  txfull_hold = 0;
  bit  reload_on_drain = 0;
  bit  reload_fd = 0;

  logic [7:0] kv[N];
  logic [7:0] pv[N];
  logic [7:0] mk[N];

  always #5 clk = ~clk;

  pixl_conv_ctrl dut (
    .clk           (clk),
    .reset         (reset),
    .rx_empty      (rx_empty),
    .r_data        (r_data),
    .rd_uart       (rd_uart),
    .tx_full       (tx_full),
    .w_data        (w_data),
    .wr_uart       (wr_uart),
    .kernel_reload (kernel_reload),
    .busy          (busy),
    .frame_done    (frame_done)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Drive at negedge, sample 4ns later (just before the rising edge).
  initial begin
    forever begin
      @(negedge clk);
      rx_empty = (rx_q.size() == 0) || (pop_cnt >= pop_limit) || (gap_cnt != 0);
      r_data   = (rx_q.size() != 0) ? rx_q[0] : 8'h00;
      tx_full  = txfull_hold || (tx_rand && ($urandom_range(0, 1) == 1));
      kernel_reload = 1'b0;
      if (reload_on_drain && rx_q.size() == 0) begin
        kernel_reload = 1'b1;
        reload_on_drain = 0;
      end
      if (reload_fd && tx_got.size() == 2 && !tx_full) begin
        kernel_reload = 1'b1;
        reload_fd = 0;
      end
      #4;
      if (rd_uart || wr_uart) chk("rd_wr_excl", {31'd0, rd_uart & wr_uart}, 0);
      if (rd_uart) begin
        chk("rd_when_empty", {31'd0, rx_empty}, 0);
        if (!rx_empty && rx_q.size() != 0) begin
          void'(rx_q.pop_front());
          pop_cnt++;
          gap_cnt = gap_rand ? $urandom_range(0, 3) : gap_len;
        end
      end else if (gap_cnt != 0) gap_cnt--;
      if (wr_uart) begin
        chk("wr_when_full", {31'd0, tx_full}, 0);
        tx_got.push_back(w_data);
        fd_got.push_back(frame_done);
      end else if (frame_done) chk("fd_without_wr", {31'd0, frame_done & ~wr_uart}, 0);
    end
  end

  task automatic do_frame(input string tag, input bit load_k, input int hold);
    int exp_v, got_v, fdv, n;
    if (load_k) for (int i = 0; i < N; i++) mk[i] = kv[i];
    exp_v = 0;
    for (int i = 0; i < N; i++) exp_v += int'(mk[i]) * int'(pv[i]);
    tx_got.delete();
    fd_got.delete();
    if (load_k) for (int i = 0; i < N; i++) rx_q.push_back(kv[i]);
    for (int i = 0; i < N; i++) rx_q.push_back(pv[i]);
    if (hold > 0) begin
      n = 0;
      while (rx_q.size() != 0 && n < 3000) begin @(negedge clk); n++; end
      repeat (hold) @(negedge clk);
      chk({tag, "_held"}, tx_got.size(), 0);
      txfull_hold = 0;
    end
    n = 0;
    while (tx_got.size() < 3 && n < 3000) begin @(negedge clk); n++; end
    repeat (3) @(negedge clk);
    chk({tag, "_nbytes"}, tx_got.size(), 3);
    got_v = 0;
    fdv = 0;
    for (int i = 0; i < tx_got.size() && i < 3; i++) begin
      got_v |= int'(tx_got[i]) << (8 * i);
      fdv   |= int'(fd_got[i]) << i;
    end
    chk({tag, "_result"}, got_v, exp_v);
    chk({tag, "_fd"}, fdv, 3'b100);
  endtask

  initial begin
    int n;
    bit next_k;
    #3;
    chk("rst_rd", {31'd0, rd_uart}, 0);
    chk("rst_wr", {31'd0, wr_uart}, 0);
    chk("rst_fd", {31'd0, frame_done}, 0);
    chk("rst_wdata", {24'd0, w_data}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    @(negedge clk); #2 reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_busy", {31'd0, busy}, 0);

    // Ramp kernel and pixels: sum i*(i+1) = 240.
    for (int i = 0; i < N; i++) begin kv[i] = 8'(i); pv[i] = 8'(i + 1); end
    do_frame("ramp", 1, 0);

    // Retained kernel; reload requested during MAC.
    reload_on_drain = 0;
    tx_got.delete();
    for (int i = 0; i < N; i++) rx_q.push_back(pv[i]);
    reload_on_drain = 1;
    for (int i = 0; i < N; i++) rx_q.delete(rx_q.size() - 1);
    do_frame("retain", 0, 0);

    // All 0xFF; reload coincides with frame_done.
    for (int i = 0; i < N; i++) begin kv[i] = 8'hFF; pv[i] = 8'hFF; end
    tx_got.delete();
    reload_fd = 1;
    do_frame("max", 1, 0);
    reload_fd = 0;

    // Five-cycle gaps between bytes, then reload during MAC.
    gap_len = 5;
    for (int i = 0; i < N; i++) begin kv[i] = 8'(i); pv[i] = 8'(i + 1); end
    reload_on_drain = 0;
    do_frame_with_drain_reload("gap5", 1);
    gap_len = 0;

    // tx_full held through the start of SEND.
    for (int i = 0; i < N; i++) begin kv[i] = 8'($urandom); pv[i] = 8'($urandom); end
    txfull_hold = 1;
    do_frame("txfull", 1, 20 + N);

    // Reset after 4 pixel bytes.
    for (int i = 0; i < N; i++) rx_q.push_back(8'($urandom));
    pop_limit = pop_cnt + 4;
    n = 0;
    while (pop_cnt < pop_limit && n < 500) begin @(negedge clk); n++; end
    chk("mid_pops", pop_cnt, pop_limit);
    chk("mid_busy", {31'd0, busy}, 1);
    @(negedge clk); #2 reset = 1'b0;
    #1;
    chk("mid_rst_rd", {31'd0, rd_uart}, 0);
    chk("mid_rst_wr", {31'd0, wr_uart}, 0);
    chk("mid_rst_fd", {31'd0, frame_done}, 0);
    chk("mid_rst_wdata", {24'd0, w_data}, 0);
    chk("mid_rst_busy", {31'd0, busy}, 0);
    pop_limit = 32'h7fff_ffff;
    n = pop_cnt;
    repeat (2) @(negedge clk);
    #3;
    chk("rst_hold_rd", {31'd0, rd_uart}, 0);
    chk("rst_hold_pops", pop_cnt, n);
    rx_q.delete();
    @(negedge clk); #2 reset = 1'b1;
    @(negedge clk);
    chk("post_rst_busy", {31'd0, busy}, 0);
    for (int i = 0; i < N; i++) begin kv[i] = 8'($urandom); pv[i] = 8'($urandom); end
    do_frame("fresh", 1, 0);

    // Random frames with random gaps, back-pressure and reloads.
    gap_rand = 1;
    tx_rand = 1;
    next_k = 0;
    for (int f = 0; f < 8; f++) begin
      bit this_k;
      this_k = next_k;
      next_k = ($urandom_range(0, 1) == 1);
      for (int i = 0; i < N; i++) begin
        kv[i] = (f == 3) ? 8'hFF : 8'($urandom);
        pv[i] = (f == 3) ? 8'hFF : 8'($urandom);
      end
      if (f == 3) this_k = 1;
      if (f == 2) next_k = 1;
      if (next_k) do_frame_with_drain_reload("rand", this_k);
      else do_frame("rand", this_k, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Arms the MAC-time reload pulse once this frame's bytes are queued.
  task automatic do_frame_with_drain_reload(input string tag, input bit load_k);
    fork
      do_frame(tag, load_k, 0);
      begin
        #1;
        reload_on_drain = 1;
      end
    join
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout got=%0d exp=%0d", 1, 0);
    $fatal(1, "timeout");
  end
endmodule
